// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
// Holds the scan FSM encoding and the digit count.
package display_scanner_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_ON  = 2'd1,
        S_GAP = 2'd2
    } scan_state_t;

endpackage

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit scanner: each digit driven DWELL cycles, then GAP blank cycles.
// Latency: a loaded value becomes visible at the next frame boundary (immediately when off).
// Backpressure: load_ready low while a value waits in the pending slot for the boundary.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        lzs_en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  nibble,
    output logic [3:0]  digit_an,
    output logic        blank,
    output logic        frame_done
);

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GP_LAST  = CNT_W'(GAP - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      active_q, active_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             fd_q, fd_d;

    logic             xfer;
    logic             direct;
    logic             boundary;
    logic [3:0]       supp;
    logic             drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            active_q   <= 16'h0000;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            fd_q       <= fd_d;
        end
    end

    assign xfer     = load_valid && !pend_vld_q;
    assign direct   = (state_q == S_OFF) || !enable;
    assign boundary = enable && (state_q == S_GAP) && (idx_q == IDX_LAST) && (cnt_q == GP_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        fd_d       = 1'b0;

        if (!enable) begin
            state_d = S_OFF;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_ON;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                S_ON: begin
                    if (cnt_q == DW_LAST) begin
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GP_LAST) begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        fd_d    = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Active only changes when nothing is being scanned or at the frame boundary.
        if (direct) begin
            if (pend_vld_q) begin
                active_d   = pend_q;
                pend_vld_d = 1'b0;
            end
            if (xfer) begin
                active_d = load_data;
            end
        end else if (boundary) begin
            if (pend_vld_q) begin
                active_d   = pend_q;
                pend_vld_d = 1'b0;
            end else if (xfer) begin
                active_d = load_data;
            end
        end else if (xfer) begin
            pend_d     = load_data;
            pend_vld_d = 1'b1;
        end
    end

    // A digit is suppressed only if it and every more significant digit are zero.
    assign supp[3] = lzs_en && (active_q[15:12] == 4'h0);
    assign supp[2] = supp[3] && (active_q[11:8] == 4'h0);
    assign supp[1] = supp[2] && (active_q[7:4] == 4'h0);
    assign supp[0] = 1'b0;

    assign drive      = (state_q == S_ON) && !supp[idx_q];
    assign digit_an   = drive ? ~(4'b0001 << idx_q) : 4'hF;
    assign blank      = !drive;
    assign nibble     = active_q[{idx_q, 2'b00} +: 4];
    assign load_ready = !pend_vld_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboarded bench for display_scanner: a frame-time model predicts every cycle's outputs.
module tb_display_scanner;

    localparam int D = 4;
    localparam int G = 1;
    localparam int S = D + G;
    localparam int P = 4 * S;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        lzs_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        load_ready;
    logic [3:0]  nibble;
    logic [3:0]  digit_an;
    logic        blank;
    logic        frame_done;

    display_scanner #(.DWELL(D), .GAP(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lzs_en     (lzs_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .nibble     (nibble),
        .digit_an   (digit_an),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic       blank;
        logic [3:0] nib;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: scanning flag, cycles since scan start, displayed and waiting values.
    bit          m_scan = 1'b0;
    int          m_t = 0;
    logic [15:0] m_act = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_pv = 1'b0;
    bit          m_fd = 1'b0;

    function automatic exp_t expect_now();
        exp_t e;
        int   ph;
        int   i;
        bit   sup;
        bit   lit;
        e.rdy = !m_pv;
        e.fd  = m_fd;
        if (!m_scan) begin
            e.an    = 4'hF;
            e.blank = 1'b1;
            e.nib   = m_act[3:0];
        end else begin
            ph      = m_t % S;
            i       = (m_t / S) % 4;
            e.nib   = 4'((m_act >> (4 * i)) & 16'h000F);
            sup     = lzs_en && (i > 0) && ((m_act >> (4 * i)) == 16'h0000);
            lit     = (ph < D) && !sup;
            e.an    = lit ? 4'(~(32'd1 << i)) : 4'hF;
            e.blank = !lit;
        end
        return e;
    endfunction

    initial begin
        forever begin
            bit xf;
            bit bnd;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_scan = 1'b0; m_t = 0; m_act = 16'h0000; m_pv = 1'b0; m_fd = 1'b0;
            end else begin
                xf = load_valid && !m_pv;
                if (!m_scan || !enable) begin
                    if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
                    if (xf) m_act = load_data;
                    m_fd   = 1'b0;
                    m_scan = enable;
                    m_t    = 0;
                end else begin
                    bnd = (m_t % P) == P - 1;
                    if (bnd) begin
                        if (m_pv) begin m_act = m_pend; m_pv = 1'b0; end
                        else if (xf) m_act = load_data;
                    end else if (xf) begin
                        m_pend = load_data; m_pv = 1'b1;
                    end
                    m_t  = m_t + 1;
                    m_fd = bnd;
                end
            end
            q.push_back(expect_now());
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk or negedge rst_n);
            #2;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
            end else begin
                e = q.pop_front();
                check("digit_an",   {12'h0, digit_an},   {12'h0, e.an});
                check("blank",      {15'h0, blank},      {15'h0, e.blank});
                check("nibble",     {12'h0, nibble},     {12'h0, e.nib});
                check("frame_done", {15'h0, frame_done}, {15'h0, e.fd});
                check("load_ready", {15'h0, load_ready}, {15'h0, e.rdy});
            end
        end
    end

    task automatic send(input logic [15:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        load_valid = 1'b1;
        load_data  = d;
        while (!acc && n < 200) begin
            acc = load_ready;
            @(negedge clk);
            n++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL load_timeout: got no acceptance of %h expected one within 200 cycles", d);
        end
        load_valid = 1'b0;
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0: return m_scan && (m_t % P == P - 1) && !m_pv;
            1: return m_scan && ((m_t / S) % 4 == 2) && (m_t % S < D);
            default: return m_scan && (m_t % S >= D);
        endcase
    endfunction

    task automatic wait_for(input int kind, input string nm);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = cond(kind);
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no matching cycle expected one within 200 cycles", nm);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Direct load while off, then scan 12AF for two frames.
        load_valid = 1'b1; load_data = 16'h12AF;
        @(negedge clk) load_valid = 1'b0; enable = 1'b1;
        repeat (45) @(negedge clk);

        // Leading-zero suppression, then back-to-back mid-frame loads.
        lzs_en = 1'b1;
        send(16'h0070);
        repeat (45) @(negedge clk);
        repeat (7) @(negedge clk);
        send(16'h1111);
        send(16'h2222);
        repeat (45) @(negedge clk);

        // Load offered exactly on the boundary cycle with the pending slot empty.
        wait_for(0, "boundary");
        load_valid = 1'b1; load_data = 16'h0305;
        @(negedge clk) load_valid = 1'b0;
        repeat (25) @(negedge clk);

        // Drop enable during digit 2 dwell.
        wait_for(1, "idx2");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (30) @(negedge clk);

        // Asynchronous reset pulse inside a blanking gap, no clock edge while low.
        wait_for(2, "gap");
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        repeat (30) @(negedge clk);

        for (int c = 0; c < 600; c++) begin
            enable     = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 15) == 0) lzs_en = ~lzs_en;
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            @(negedge clk);
        end
        load_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
